// File: rtl/param_mod_counter_pkg.sv
//==============================================================================
// Module   : clock_pkg
// Purpose  : Shared moduli/width constants for the digital-clock counter chain.
// Revision : 1.0
//==============================================================================
`default_nettype none

package clock_pkg;

    localparam int SEC_MOD       = 60;
    localparam int MIN_MOD       = 60;
    localparam int HR_MOD        = 24;
    localparam int DEFAULT_WIDTH = 6;

    // Width is capped so that 1 << width stays a positive int.
    function automatic bit modulus_ok(input int width, input int modulus);
        return (width >= 1) && (width <= 30) && (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_mod_counter_if.sv
//==============================================================================
// Module   : param_mod_counter_if
// Purpose  : Control and status bundle of one modulo counter stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface param_mod_counter_if
    import clock_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             clear;
    logic             en;
    logic             load;
    logic             up_dn;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             rollover;
    logic             load_err;

    modport master (
        output clear, en, load, up_dn, in,
        input  out, tc, rollover, load_err
    );

    modport slave (
        input  clear, en, load, up_dn, in,
        output out, tc, rollover, load_err
    );

endinterface

`default_nettype wire

// File: rtl/param_mod_counter_next.sv
//==============================================================================
// Module   : mod_counter_next
// Purpose  : Combinational next-count, terminal-count and load range check.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mod_counter_next
    import clock_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = SEC_MOD
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] nxt,
    output logic             tc,
    output logic             load_bad
);

    // Comparing against MODULUS-1 keeps all arithmetic in WIDTH bits, even for MODULUS = 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic at_top;
    logic at_bottom;
    logic in_range;

    assign at_top    = (cur == MAX_VAL);
    assign at_bottom = (cur == '0);
    assign in_range  = (load_val <= MAX_VAL);

    assign tc       = en & ~clear & ~load & (up_dn ? at_top : at_bottom);
    assign load_bad = load & ~clear & ~in_range;

    always_comb begin
        nxt = cur;
        if (clear) begin
            nxt = '0;
        end else if (load) begin
            nxt = in_range ? load_val : '0;
        end else if (en) begin
            if (up_dn) begin
                nxt = at_top ? '0 : cur + WIDTH'(1);
            end else begin
                nxt = at_bottom ? MAX_VAL : cur - WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/param_mod_counter.sv
//==============================================================================
// Module   : param_mod_counter
// Purpose  : Cascadable up/down modulo-MODULUS counter with load and pulses.
// Revision : 1.0
//==============================================================================
`default_nettype none

module param_mod_counter
    import clock_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = SEC_MOD
) (
    input  logic                clk,
    input  logic                reset,
    param_mod_counter_if.slave  bus
);

    generate
        if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_params
            $error("param_mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_w;
    logic             load_bad_w;
    logic             wrap_pulse;
    logic             load_err_pulse;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .cur      (count),
        .clear    (bus.clear),
        .en       (bus.en),
        .load     (bus.load),
        .up_dn    (bus.up_dn),
        .load_val (bus.in),
        .nxt      (count_nxt),
        .tc       (tc_w),
        .load_bad (load_bad_w)
    );

    // tc already folds in clear/load, so registering it gives the wrap pulse directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count          <= '0;
            wrap_pulse     <= 1'b0;
            load_err_pulse <= 1'b0;
        end else begin
            count          <= count_nxt;
            wrap_pulse     <= tc_w;
            load_err_pulse <= load_bad_w;
        end
    end

    assign bus.out      = count;
    assign bus.tc       = tc_w;
    assign bus.rollover = wrap_pulse;
    assign bus.load_err = load_err_pulse;

endmodule

`default_nettype wire

// File: tb/tb_param_mod_counter.sv
//==============================================================================
// Module   : tb_param_mod_counter
// Purpose  : Self-checking bench: single mod-60 stage plus a 60/60/24 chain.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_param_mod_counter;

    logic clk;
    logic reset;

    param_mod_counter_if #(.WIDTH(6)) bus();
    param_mod_counter_if #(.WIDTH(6)) sec_if();
    param_mod_counter_if #(.WIDTH(6)) min_if();
    param_mod_counter_if #(.WIDTH(6)) hr_if();

    param_mod_counter #(.WIDTH(6), .MODULUS(60)) dut (.clk(clk), .reset(reset), .bus(bus));
    param_mod_counter #(.WIDTH(6), .MODULUS(60)) u_sec (.clk(clk), .reset(reset), .bus(sec_if));
    param_mod_counter #(.WIDTH(6), .MODULUS(60)) u_min (.clk(clk), .reset(reset), .bus(min_if));
    param_mod_counter #(.WIDTH(6), .MODULUS(24)) u_hr  (.clk(clk), .reset(reset), .bus(hr_if));

    assign min_if.en = sec_if.tc;
    assign hr_if.en  = min_if.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clear;
        logic       load;
        logic       en;
        logic       up_dn;
        logic [5:0] in;
        logic       exp_tc;
        logic [5:0] exp_out;
        logic       exp_roll;
        logic       exp_lerr;
    } vec_t;

    typedef struct {
        logic [5:0] out;
        logic       roll;
        logic       lerr;
    } exp_t;

    vec_t vecs[15];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [5:0] v);
        bus.clear = c;
        bus.load  = l;
        bus.en    = e;
        bus.up_dn = u;
        bus.in    = v;
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                                input logic [5:0] v, input logic t, input logic [5:0] o,
                                input logic r, input logic le);
        vec_t x;
        x.clear = c; x.load = l; x.en = e; x.up_dn = u; x.in = v;
        x.exp_tc = t; x.exp_out = o; x.exp_roll = r; x.exp_lerr = le;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   rolls;

        //             clr ld  en  up  in     tc  out   roll lerr
        vecs[0]  = mk(0, 1, 0, 1, 6'd45, 0, 6'd45, 0, 0);
        vecs[1]  = mk(0, 1, 0, 1, 6'd63, 0, 6'd0,  0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 6'd0,  0, 6'd0,  0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 6'd0,  0, 6'd1,  0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 6'd0,  0, 6'd0,  0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 6'd0,  1, 6'd59, 1, 0);
        vecs[6]  = mk(0, 0, 1, 1, 6'd0,  1, 6'd0,  1, 0);
        vecs[7]  = mk(1, 1, 1, 1, 6'd10, 0, 6'd0,  0, 0);
        vecs[8]  = mk(0, 1, 1, 1, 6'd10, 0, 6'd10, 0, 0);
        vecs[9]  = mk(0, 1, 0, 1, 6'd59, 0, 6'd59, 0, 0);
        vecs[10] = mk(1, 0, 1, 1, 6'd0,  0, 6'd0,  0, 0);
        vecs[11] = mk(0, 1, 1, 1, 6'd60, 0, 6'd0,  0, 1);
        vecs[12] = mk(0, 0, 0, 1, 6'd0,  0, 6'd0,  0, 0);
        vecs[13] = mk(0, 0, 0, 0, 6'd0,  0, 6'd0,  0, 0);
        vecs[14] = mk(1, 1, 0, 1, 6'd63, 0, 6'd0,  0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 1, 6'd0);
        sec_if.clear = 0; sec_if.load = 0; sec_if.en = 0; sec_if.up_dn = 1; sec_if.in = 6'd0;
        min_if.clear = 0; min_if.load = 0; min_if.up_dn = 1; min_if.in = 6'd0;
        hr_if.clear  = 0; hr_if.load  = 0; hr_if.up_dn  = 1; hr_if.in  = 6'd0;

        #3;
        chk("reset_out", bus.out, 0);
        chk("reset_roll", bus.rollover, 0);
        chk("reset_lerr", bus.load_err, 0);
        drive(0, 0, 1, 0, 6'd0);
        #1 chk("reset_tc_down", bus.tc, 1);
        drive(0, 0, 0, 1, 6'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].clear, vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].in);
            #1 chk($sformatf("vec%0d_tc", i), bus.tc, vecs[i].exp_tc);
            sbq.push_back('{vecs[i].exp_out, vecs[i].exp_roll, vecs[i].exp_lerr});
            @(posedge clk); #1;
            e = sbq.pop_front();
            chk($sformatf("vec%0d_out", i), bus.out, e.out);
            chk($sformatf("vec%0d_roll", i), bus.rollover, e.roll);
            chk($sformatf("vec%0d_lerr", i), bus.load_err, e.lerr);
        end

        // Full 60-edge up count from 0 with a single rollover pulse
        rolls = 0;
        drive(0, 0, 1, 1, 6'd0);
        for (int i = 0; i < 60; i++) begin
            #1;
            chk($sformatf("cnt%0d_out", i), bus.out, i);
            chk($sformatf("cnt%0d_tc", i), bus.tc, (i == 59) ? 1 : 0);
            @(posedge clk); #1;
            if (bus.rollover === 1'b1) rolls++;
        end
        chk("cnt_wrap_out", bus.out, 0);
        drive(0, 0, 0, 1, 6'd0);
        @(posedge clk); #1;
        if (bus.rollover === 1'b1) rolls++;
        chk("cnt_roll_count", rolls, 1);

        // Asynchronous reset between edges while sitting on a pending wrap
        drive(0, 1, 0, 1, 6'd59);
        @(posedge clk); #1;
        drive(0, 0, 1, 1, 6'd0);
        #1 chk("rst_pre_tc", bus.tc, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_out", bus.out, 0);
        chk("rst_async_tc", bus.tc, 0);
        chk("rst_async_roll", bus.rollover, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 0, 1, 6'd0);
        @(posedge clk); #1;
        chk("rst_after_roll", bus.rollover, 0);
        chk("rst_after_out", bus.out, 0);
        drive(0, 0, 1, 1, 6'd0);
        @(posedge clk); #1;
        chk("rst_resume_out", bus.out, 1);
        chk("rst_resume_roll", bus.rollover, 0);

        // Clock chain 23:59:59 -> 00:00:00
        sec_if.load = 1; sec_if.in = 6'd59;
        min_if.load = 1; min_if.in = 6'd59;
        hr_if.load  = 1; hr_if.in  = 6'd23;
        @(posedge clk); #1;
        sec_if.load = 0; min_if.load = 0; hr_if.load = 0;
        chk("chain_pre_sec", sec_if.out, 59);
        chk("chain_pre_min", min_if.out, 59);
        chk("chain_pre_hr", hr_if.out, 23);
        sec_if.en = 1;
        #1;
        chk("chain_sec_tc", sec_if.tc, 1);
        chk("chain_min_tc", min_if.tc, 1);
        chk("chain_hr_tc", hr_if.tc, 1);
        @(posedge clk); #1;
        chk("chain_sec_out", sec_if.out, 0);
        chk("chain_min_out", min_if.out, 0);
        chk("chain_hr_out", hr_if.out, 0);
        chk("chain_sec_roll", sec_if.rollover, 1);
        chk("chain_min_roll", min_if.rollover, 1);
        chk("chain_hr_roll", hr_if.rollover, 1);
        @(posedge clk); #1;
        chk("chain_next_sec", sec_if.out, 1);
        chk("chain_next_min", min_if.out, 0);
        chk("chain_next_roll", sec_if.rollover, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/param_mod_counter.md
PARAM_MOD_COUNTER -- requirements
Module: param_mod_counter

Interface
REQ-001 Parameter WIDTH, default 6: counter register width in bits.
REQ-002 Parameter MODULUS, default 60: count range is 0..MODULUS-1; legal only when 2 <= MODULUS <= 2**WIDTH.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 clear  input  1  synchronous clear to 0, active-high.
REQ-006 en  input  1  count enable; also the carry-in for cascading.
REQ-007 load  input  1  synchronous parallel load of in, active-high.
REQ-008 up_dn  input  1  count direction: 1 = up, 0 = down.
REQ-009 in  input  WIDTH  parallel load value.
REQ-010 out  output  WIDTH  registered count value.
REQ-011 tc  output  1  combinational terminal count, the carry-out to the next stage.
REQ-012 rollover  output  1  registered one-cycle pulse marking a completed wrap.
REQ-013 load_err  output  1  registered one-cycle pulse marking a rejected load value.

Function
REQ-014 Next-state priority on each clk edge is clear > load > en > hold.
REQ-015 clear=1 drives out to 0 and forces rollover=0 and load_err=0 for that cycle.
REQ-016 With load=1 and in < MODULUS, out takes the value of in.
REQ-017 With load=1 and in >= MODULUS, out goes to 0 and load_err pulses high for exactly one cycle.
REQ-018 With en=1 and up_dn=1, out increments by 1; out = MODULUS-1 wraps to 0.
REQ-019 With en=1 and up_dn=0, out decrements by 1; out = 0 wraps to MODULUS-1.
REQ-020 With en=0, clear=0 and load=0, out holds its value.
REQ-021 tc = en & ~clear & ~load & (up_dn ? out==MODULUS-1 : out==0), with no register stage.
REQ-022 rollover is 1 in the cycle after any edge where tc was 1; it is 0 in every other cycle.
REQ-023 Cascading is done by driving the next stage's en from this stage's tc; stages then advance on the same edge with zero added latency.
REQ-024 Latency from any control input to out is exactly one clk edge.
REQ-025 All count arithmetic is performed in WIDTH bits; out never holds a value >= MODULUS, even when MODULUS = 2**WIDTH.
REQ-026 A direction change while en=1 takes effect on the same edge; no extra state is kept.
REQ-027 load=1 together with en=1 loads the value; neither tc nor rollover is generated.
REQ-028 A parameter set outside the legal range in REQ-002 stops elaboration with an error.

Reset
REQ-029 reset=1 asynchronously forces out=0, rollover=0 and load_err=0, independent of clk.
REQ-030 Reset asserted mid-count aborts any pending load or wrap; no rollover or load_err pulse is produced after reset release.
REQ-031 Counting resumes on the first clk edge after reset deasserts, from value 0.
REQ-032 tc during reset follows REQ-021 with out=0, so tc = en & ~up_dn & ~clear & ~load.

Structure
REQ-033 The shared package clock_pkg holds the constants SEC_MOD=60, MIN_MOD=60, HR_MOD=24 and DEFAULT_WIDTH=6.
REQ-034 One combinational sub-module, mod_counter_next, computes the next value, tc and the load range check.
REQ-035 All state registers stay in the top module: out, rollover and load_err.
REQ-036 A digital-clock chain is built as three instances of this module: seconds (60), minutes (60) and hours (24), linked tc to en.

Verification
REQ-037 Count up, WIDTH=6, MODULUS=60, en=1, up_dn=1, from out=0 for 60 edges -> out is 59 before the 60th edge and 0 after it; tc is 1 only at out=59; rollover pulses once.
REQ-038 Count down from out=0 with up_dn=0, en=1 -> out goes to 59 on the next edge, tc=1 at out=0, rollover pulses for one cycle.
REQ-039 load=1 with in=45 -> out=45 and load_err=0; load=1 with in=63 -> out=0 and load_err pulses for one cycle.
REQ-040 clear, load (in=10) and en all high on one edge -> out=0; then load and en high with in=10 -> out=10 and no tc.
REQ-041 Three-stage chain (60/60/24) preset to 23:59:59 with en=1 -> the next edge gives 00:00:00, with all three rollover outputs pulsing on the same cycle.
REQ-042 reset asserted between clk edges while out=59 and tc=1 -> out is 0 immediately; no rollover pulse follows reset release.
